raster_stream_source: RTL and testbench

//  Transmit side of the window-fetcher pixel stream. On start_i, reads one frame

---
 rtl/raster_stream_source.sv | 156 +++++++++++++++
 tb/tb_raster_stream_source.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_stream_source.sv
// raster_stream_source
// Reads one frame from a synchronous frame-buffer read port in raster order
// and presents it as a pixel stream (data/col/row/valid) for the window
// fetcher. Optional idle cycles after each row and after the frame give
// downstream line buffers time to settle.
module raster_stream_source #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 20,
  parameter int LINE_GAP     = 0,
  parameter int FRAME_GAP    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o
);

  localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  localparam logic [15:0]      LAST_COL  = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]      LAST_ROW  = 16'(IMAGE_HEIGHT - 1);
  localparam logic [GAP_W-1:0] LGAP_LAST = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [GAP_W-1:0] FGAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LGAP,
    FGAP,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             col_q, row_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [GAP_W-1:0]        gap_q;
  logic                    valid_q;
  logic [15:0]             col_out_q, row_out_q;
  logic [DATA_WIDTH-1:0]   data_hold_q;
  logic                    last_col, last_row;

  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from pre-edge values, independent of order.
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    mem_rd_o = 1'b0;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = READ;
      end
      READ: begin
        mem_rd_o = 1'b1;
        if (last_col) begin
          if (last_row)          state_d = (FRAME_GAP > 0) ? FGAP : DONE;
          else if (LINE_GAP > 0) state_d = LGAP;
        end
      end
      LGAP: if (gap_q == LGAP_LAST) state_d = READ;
      FGAP: if (gap_q == FGAP_LAST) state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster counters: column/row and a running linear address (no multiplier).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
          end
        end
        READ: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (last_col) begin
            col_q <= '0;
            if (!last_row) row_q <= row_q + 16'd1;
          end else begin
            col_q <= col_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gap cycle counter; restarts from zero on every pass through READ.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                  gap_q <= '0;
    else if (state_q == LGAP || state_q == FGAP) gap_q <= gap_q + GAP_W'(1);
    else                                         gap_q <= '0;
  end

  // Output pipeline: coordinates travel one cycle alongside the read so they
  // line up with the read data returned by the frame buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q     <= 1'b0;
      col_out_q   <= '0;
      row_out_q   <= '0;
      data_hold_q <= '0;
    end else begin
      valid_q <= mem_rd_o;
      if (mem_rd_o) begin
        col_out_q <= col_q;
        row_out_q <= row_q;
      end
      if (valid_q) data_hold_q <= mem_data_i;
    end
  end

  // Read data passes straight through on valid cycles; otherwise the last
  // pixel is held so data_o is stable between pixels.
  assign data_o     = valid_q ? mem_data_i : data_hold_q;
  assign mem_addr_o = addr_q;
  assign col_o      = col_out_q;
  assign row_o      = row_out_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_raster_stream_source.sv
// tb_raster_stream_source
// Three instances (4x3 no gaps, 4x3 with row/frame gaps, 1x1) share clock,
// reset and start. A frame-level reference model turns each accepted start
// into a list of expected pixels (cycle, address, data, coordinates) and a
// done cycle; a monitor compares every cycle against those expectations.
module tb_raster_stream_source;

  localparam int N = 3;
  localparam int W_P  [N] = '{4, 4, 1};
  localparam int H_P  [N] = '{3, 3, 1};
  localparam int LG_P [N] = '{0, 2, 0};
  localparam int FG_P [N] = '{0, 3, 0};

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] data;
    logic [15:0] col;
    logic [15:0] row;
  } pix_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy  [N];
  logic        done  [N];
  logic        rd    [N];
  logic        valid [N];
  logic [19:0] addr  [N];
  logic [15:0] mdata [N];
  logic [15:0] data  [N];
  logic [15:0] col   [N];
  logic [15:0] row   [N];

  pix_t        pq [N][$];
  int          dq [N][$];
  int          busy_start [N];
  int          busy_end   [N];
  logic [15:0] last_d [N];
  logic [15:0] last_c [N];
  logic [15:0] last_r [N];

  int cyc        = 0;
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer content as a function of the linear pixel address.
  function automatic logic [15:0] pix(input int a);
    return 16'(a * 40503 + 4660);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    raster_stream_source #(
      .DATA_WIDTH  (16),
      .IMAGE_WIDTH (W_P[g]),
      .IMAGE_HEIGHT(H_P[g]),
      .ADDR_WIDTH  (20),
      .LINE_GAP    (LG_P[g]),
      .FRAME_GAP   (FG_P[g])
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .start_i   (start),
      .busy_o    (busy[g]),
      .done_o    (done[g]),
      .mem_rd_o  (rd[g]),
      .mem_addr_o(addr[g]),
      .mem_data_i(mdata[g]),
      .data_o    (data[g]),
      .col_o     (col[g]),
      .row_o     (row[g]),
      .valid_o   (valid[g])
    );
  end

  // Synchronous frame buffers: data one cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (rd[i]) mdata[i] <= pix(int'(addr[i]));
  end

  task automatic check(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, want %0h", name, idx, cyc, act, exp);
    end
  endtask

  // Reference model: a start in cycle c is taken by every instance that is
  // idle; the frame occupies W*H read cycles, (H-1)*LINE_GAP row gaps,
  // FRAME_GAP end gap and one done cycle.
  task automatic model_start(input int c);
    for (int i = 0; i < N; i++) begin
      if (c > busy_end[i]) begin
        int len;
        len = W_P[i] * H_P[i] + (H_P[i] - 1) * LG_P[i] + FG_P[i] + 1;
        busy_start[i] = c + 1;
        busy_end[i]   = c + len;
        for (int r = 0; r < H_P[i]; r++) begin
          for (int cl = 0; cl < W_P[i]; cl++) begin
            pix_t p;
            p.cyc  = c + 2 + r * (W_P[i] + LG_P[i]) + cl;
            p.addr = r * W_P[i] + cl;
            p.data = pix(p.addr);
            p.col  = 16'(cl);
            p.row  = 16'(r);
            pq[i].push_back(p);
          end
        end
        dq[i].push_back(c + len);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      dq[i].delete();
      busy_start[i] = 0;
      busy_end[i]   = -1;
      last_d[i]     = '0;
      last_c[i]     = '0;
      last_r[i]     = '0;
    end
  endtask

  // One stimulus cycle: start is visible for the current cycle.
  task automatic step(input bit s);
    start = s;
    if (s && rst_n) model_start(cyc);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      step(1'b0);
      guard++;
    end
    if (cyc < t) check("wait_bound", 0, 128'(cyc), 128'(t));
  endtask

  task automatic drain();
    int m = 0;
    for (int i = 0; i < N; i++) if (busy_end[i] > m) m = busy_end[i];
    wait_until(m + 3);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        check("reset_ctl", i, 128'({busy[i], done[i], rd[i], valid[i], addr[i]}), '0);
        check("reset_pix", i, 128'({data[i], col[i], row[i]}), '0);
      end else begin
        bit exp_v, exp_done, exp_rd;
        check("busy", i, 128'(busy[i]),
              128'(cyc >= busy_start[i] && cyc <= busy_end[i]));

        exp_v = (pq[i].size() > 0) && (pq[i][0].cyc == cyc);
        check("valid", i, 128'(valid[i]), 128'(exp_v));
        if (exp_v) begin
          pix_t p;
          p = pq[i].pop_front();
          if (valid[i]) begin
            check("data", i, 128'(data[i]), 128'(p.data));
            check("col_row", i, 128'({col[i], row[i]}), 128'({p.col, p.row}));
          end
          last_d[i] = p.data;
          last_c[i] = p.col;
          last_r[i] = p.row;
        end else if (!valid[i]) begin
          check("hold", i, 128'({data[i], col[i], row[i]}),
                128'({last_d[i], last_c[i], last_r[i]}));
        end

        exp_done = (dq[i].size() > 0) && (dq[i][0] == cyc);
        check("done", i, 128'(done[i]), 128'(exp_done));
        if (exp_done) void'(dq[i].pop_front());

        exp_rd = (pq[i].size() > 0) && (pq[i][0].cyc == cyc + 1);
        check("mem_rd", i, 128'(rd[i]), 128'(exp_rd));
        if (exp_rd && rd[i]) check("mem_addr", i, 128'(addr[i]), 128'(pq[i][0].addr));
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Plain frame; a start pulse mid-frame is ignored by the busy instances.
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    // Start on the done cycle of instance 0 (ignored), then one cycle later.
    wait_until(busy_end[0]);
    step(1'b1);
    step(1'b1);
    drain();

    // Reset in the middle of a frame, then a clean restart.
    step(1'b1);
    wait_until(busy_start[1] + 5);
    rst_n = 1'b0;
    model_reset();
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    repeat (6) step(1'b0);
    step(1'b1);
    drain();

    // Random start pulses.
    for (int k = 0; k < 200; k++) step($urandom_range(0, 5) == 0);
    drain();

    for (int i = 0; i < N; i++) begin
      check("pixels_left", i, 128'(pq[i].size()), '0);
      check("dones_left", i, 128'(dq[i].size()), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
